ad9364_dac_pattern_gen: RTL and testbench

Parametrised DAC test-pattern source for the AD9364 digital interface. It sits in the `clk` domain between user logic and the interface core's `dac_valid`/`dac_data_*`/`dac_r1_mode` inputs. It generates constant, square, ramp or PN15 I/Q samples for one or two channels. It strobes `dac_valid` at the interface cadence: every 2 cycles in 1-channel mode, every 4 cycles in 2-channel mode.

---
 rtl/ad9364_dac_pattern_gen.sv | 170 +++++++++++++++++
 tb/tb_ad9364_dac_pattern_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9364_dac_pattern_gen.sv
// -----------------------------------------------------------------------------
// ad9364_dac_pattern_gen
// Test-pattern source for the AD9364 DAC path. Emits constant, square, ramp or
// PN15 I/Q samples, strobed at the interface cadence: every 2 cycles in
// one-channel mode, every 4 cycles in two-channel mode.
//
// Ports
//   clk, rst           single clock, synchronous active-high reset
//   enable             run generator; low drops strobes and restarts patterns
//   mode               0 constant, 1 square, 2 ramp, 3 PN15
//   r1_mode            1 = one channel (1R1T), 0 = two channels
//   half_period        square half-period in samples (0 behaves as 1)
//   ramp_step          ramp increment per sample
//   const_i, const_q   constant-mode sample values
//   dac_valid          one-cycle sample strobe
//   dac_data_i1/q1/i2/q2  sample words, updated only on strobes
//   dac_r1_mode        channel mode latched at the last strobe
// -----------------------------------------------------------------------------
module ad9364_dac_pattern_gen #(
  parameter int DATA_WIDTH   = 12,
  parameter int NUM_CHANNELS = 2,
  parameter int DIV_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic                  r1_mode,
  input  logic [DIV_WIDTH-1:0]  half_period,
  input  logic [DATA_WIDTH-1:0] ramp_step,
  input  logic [DATA_WIDTH-1:0] const_i,
  input  logic [DATA_WIDTH-1:0] const_q,
  output logic                  dac_valid,
  output logic [DATA_WIDTH-1:0] dac_data_i1,
  output logic [DATA_WIDTH-1:0] dac_data_q1,
  output logic [DATA_WIDTH-1:0] dac_data_i2,
  output logic [DATA_WIDTH-1:0] dac_data_q2,
  output logic                  dac_r1_mode
);

  localparam logic [14:0]           LFSR_INIT = 15'h7FFF;
  localparam logic [DATA_WIDTH-1:0] Q_OFFSET  = {2'b01, {(DATA_WIDTH-2){1'b0}}};

  // Full-scale square amplitude; phase 0 is the positive half.
  function automatic logic [DATA_WIDTH-1:0] square_word(input logic neg);
    return neg ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  endfunction

  logic [1:0]            cad_q, cad_d;
  logic                  valid_q, valid_d;
  logic                  r1e_q, r1e_d;
  logic [1:0]            mode_q, mode_d;
  logic                  phase_q, phase_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [14:0]           lfsr_q, lfsr_d;
  logic [DATA_WIDTH-1:0] i1_q, i1_d, q1_q, q1_d, i2_q, i2_d, q2_q, q2_d;

  logic                  r1e_in;
  logic                  restart;
  logic [1:0]            cad_last;
  logic [DIV_WIDTH-1:0]  cnt_last;
  // Pattern state as seen by this cycle: a mode change restarts the pattern
  // immediately, so a strobe on the change cycle already carries sample 0.
  logic                  ph;
  logic [DIV_WIDTH-1:0]  cn;
  logic [DATA_WIDTH-1:0] ac;
  logic [14:0]           lf;

  always_comb begin
    r1e_in   = (NUM_CHANNELS == 1) ? 1'b1 : r1_mode;
    restart  = (mode != mode_q);
    cad_last = r1e_q ? 2'd1 : 2'd3;
    cnt_last = (half_period == '0) ? '0 : half_period - DIV_WIDTH'(1);
    ph       = restart ? 1'b0      : phase_q;
    cn       = restart ? '0        : cnt_q;
    ac       = restart ? '0        : acc_q;
    lf       = restart ? LFSR_INIT : lfsr_q;

    cad_d   = cad_q;
    valid_d = 1'b0;
    r1e_d   = r1e_q;
    mode_d  = mode;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lfsr_d  = lfsr_q;
    i1_d    = i1_q;
    q1_d    = q1_q;
    i2_d    = i2_q;
    q2_d    = q2_q;

    if (!enable) begin
      cad_d   = 2'd0;
      phase_d = 1'b0;
      cnt_d   = '0;
      acc_d   = '0;
      lfsr_d  = LFSR_INIT;
    end else if (cad_q == 2'd0) begin
      // Strobe: latch channel mode, emit one sample, advance pattern state.
      valid_d = 1'b1;
      r1e_d   = r1e_in;
      cad_d   = 2'd1;
      case (mode)
        2'd0: begin i1_d = const_i;          q1_d = const_q;       end
        2'd1: begin i1_d = square_word(ph);  q1_d = '0;            end
        2'd2: begin i1_d = ac;               q1_d = ac + Q_OFFSET; end
        2'd3: begin i1_d = lf[DATA_WIDTH-1:0]; q1_d = ~lf[DATA_WIDTH-1:0]; end
      endcase
      i2_d = r1e_in ? '0 : ~i1_d;
      q2_d = r1e_in ? '0 : ~q1_d;
      // >= keeps the divider bounded if half_period shrinks mid-run.
      if (cn >= cnt_last) begin
        cnt_d   = '0;
        phase_d = ~ph;
      end else begin
        cnt_d   = cn + DIV_WIDTH'(1);
        phase_d = ph;
      end
      acc_d  = ac + ramp_step;
      lfsr_d = {lf[13:0], lf[14] ^ lf[13]};
    end else begin
      cad_d = (cad_q == cad_last) ? 2'd0 : cad_q + 2'd1;
      if (restart) begin
        phase_d = 1'b0;
        cnt_d   = '0;
        acc_d   = '0;
        lfsr_d  = LFSR_INIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cad_q   <= 2'd0;
      valid_q <= 1'b0;
      r1e_q   <= 1'b1;
      mode_q  <= 2'd0;
      phase_q <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      lfsr_q  <= LFSR_INIT;
      i1_q    <= '0;
      q1_q    <= '0;
      i2_q    <= '0;
      q2_q    <= '0;
    end else begin
      cad_q   <= cad_d;
      valid_q <= valid_d;
      r1e_q   <= r1e_d;
      mode_q  <= mode_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lfsr_q  <= lfsr_d;
      i1_q    <= i1_d;
      q1_q    <= q1_d;
      i2_q    <= i2_d;
      q2_q    <= q2_d;
    end
  end

  assign dac_valid   = valid_q;
  assign dac_data_i1 = i1_q;
  assign dac_data_q1 = q1_q;
  assign dac_data_i2 = i2_q;
  assign dac_data_q2 = q2_q;
  assign dac_r1_mode = r1e_q;

endmodule

// File: tb/tb_ad9364_dac_pattern_gen.sv
// Scoreboard bench: a behavioural model derives each sample from its index
// since the last pattern restart and pushes it; a monitor pops on dac_valid.
module tb_ad9364_dac_pattern_gen;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst, enable, r1_mode;
  logic [1:0]    mode;
  logic [15:0]   half_period;
  logic [DW-1:0] ramp_step, const_i, const_q;
  logic          dac_valid, dac_r1_mode;
  logic [DW-1:0] dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2;

  ad9364_dac_pattern_gen #(.DATA_WIDTH(DW), .NUM_CHANNELS(2), .DIV_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .r1_mode(r1_mode),
    .half_period(half_period), .ramp_step(ramp_step),
    .const_i(const_i), .const_q(const_q),
    .dac_valid(dac_valid),
    .dac_data_i1(dac_data_i1), .dac_data_q1(dac_data_q1),
    .dac_data_i2(dac_data_i2), .dac_data_q2(dac_data_q2),
    .dac_r1_mode(dac_r1_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [DW-1:0] i1, q1, i2, q2;
    logic        r1;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  logic [14:0]   pn[32767];
  logic [DW-1:0] hold_i1 = '0, hold_q1 = '0, hold_i2 = '0, hold_q2 = '0;
  logic          exp_r1 = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // PN15 sequence x^15+x^14+1 from the all-ones seed.
  initial begin
    logic [14:0] s;
    s = 15'h7FFF;
    for (int k = 0; k < 32767; k++) begin
      pn[k] = s;
      s = {s[13:0], s[14] ^ s[13]};
    end
  end

  function automatic exp_t model_sample(input int n, input logic [1:0] m, input logic r1e);
    exp_t e;
    int   hp;
    e.due = cyc;
    e.r1  = r1e;
    case (m)
      2'd0: begin e.i1 = const_i; e.q1 = const_q; end
      2'd1: begin
        hp = (half_period == 0) ? 1 : int'(half_period);
        e.i1 = (((n / hp) % 2) == 0) ? 12'h7FF : 12'h800;
        e.q1 = '0;
      end
      2'd2: begin
        e.i1 = DW'(n * int'(ramp_step));
        e.q1 = DW'(n * int'(ramp_step) + (1 << (DW - 2)));
      end
      default: begin
        e.i1 = pn[n % 32767][DW-1:0];
        e.q1 = ~e.i1;
      end
    endcase
    e.i2 = r1e ? '0 : ~e.i1;
    e.q2 = r1e ? '0 : ~e.q1;
    return e;
  endfunction

  // Reference model: n = samples since last restart, cd = cycles to next strobe.
  int         n = 0;
  int         cd = 0;
  logic [1:0] prev_mode = 2'd0;
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      n = 0; cd = 0; exp_r1 = 1'b1;
      hold_i1 = '0; hold_q1 = '0; hold_i2 = '0; hold_q2 = '0;
    end else if (!enable) begin
      n = 0; cd = 0;
    end else begin
      if (mode != prev_mode) n = 0;
      if (cd == 0) begin
        e = model_sample(n, mode, r1_mode);
        sb.push_back(e);
        hold_i1 = e.i1; hold_q1 = e.q1; hold_i2 = e.i2; hold_q2 = e.q2;
        exp_r1 = e.r1;
        n++;
        cd = r1_mode ? 1 : 3;
      end else begin
        cd--;
      end
    end
    prev_mode = mode;
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (dac_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_strobe: got valid expected none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("sb_due", cyc, e.due);
        chk("sb_i1", dac_data_i1, e.i1);
        chk("sb_q1", dac_data_q1, e.q1);
        chk("sb_i2", dac_data_i2, e.i2);
        chk("sb_q2", dac_data_q2, e.q2);
      end
    end else begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        total++; bad++;
        $display("FAIL missed_strobe: got none expected strobe due %0d (cycle %0d)", sb[0].due, cyc);
        void'(sb.pop_front());
      end
      chk("hold_i1", dac_data_i1, hold_i1);
      chk("hold_q1", dac_data_q1, hold_q1);
      chk("hold_i2", dac_data_i2, hold_i2);
      chk("hold_q2", dac_data_q2, hold_q2);
    end
    chk("r1_mode_out", dac_r1_mode, exp_r1);
  end

  task automatic expect_strobe(input string nm, input logic [DW-1:0] e);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (dac_valid !== 1'b1 && k < 8);
    if (dac_valid !== 1'b1) begin
      total++; bad++;
      $display("FAIL %s: got no strobe within 8 cycles expected i1 %h", nm, e);
    end else begin
      chk(nm, dac_data_i1, e);
    end
  endtask

  initial begin
    int len;
    rst = 1'b1; enable = 1'b0; mode = 2'd0; r1_mode = 1'b1;
    half_period = 16'd2; ramp_step = '0; const_i = '0; const_q = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", dac_valid, 1'b0);
    chk("rst_i1", dac_data_i1, 12'h000);
    chk("rst_r1", dac_r1_mode, 1'b1);

    // Square, one channel, half_period 2; first strobe one cycle after enable.
    rst = 1'b0; mode = 2'd1; r1_mode = 1'b1; half_period = 16'd2; enable = 1'b1;
    @(negedge clk);
    chk("sq_first_latency", dac_valid, 1'b1);
    chk("sq_s0", dac_data_i1, 12'h7FF);
    expect_strobe("sq_s1", 12'h7FF);
    expect_strobe("sq_s2", 12'h800);
    expect_strobe("sq_s3", 12'h800);
    expect_strobe("sq_s4", 12'h7FF);

    // Ramp, two channels, step -1.
    enable = 1'b0;
    @(negedge clk);
    r1_mode = 1'b0; mode = 2'd2; ramp_step = 12'hFFF; enable = 1'b1;
    expect_strobe("ramp_s0", 12'h000);
    expect_strobe("ramp_s1", 12'hFFF);
    expect_strobe("ramp_s2", 12'hFFE);

    // Mid-run switch to PN15.
    mode = 2'd3;
    expect_strobe("pn_s0", 12'hFFF);
    expect_strobe("pn_s1", 12'hFFE);
    expect_strobe("pn_s2", 12'hFFC);
    expect_strobe("pn_s3", 12'hFF8);

    // half_period 0 toggles every sample.
    enable = 1'b0;
    @(negedge clk);
    mode = 2'd1; half_period = 16'd0; r1_mode = 1'b1; enable = 1'b1;
    expect_strobe("hp0_s0", 12'h7FF);
    expect_strobe("hp0_s1", 12'h800);
    expect_strobe("hp0_s2", 12'h7FF);

    // Ramp then constant mid-run.
    mode = 2'd2; ramp_step = 12'd5;
    expect_strobe("rc_ramp_s0", 12'h000);
    const_i = 12'h123; const_q = 12'h456; mode = 2'd0;
    expect_strobe("rc_const", 12'h123);

    // Reset during two-channel ramp, enable held high.
    r1_mode = 1'b0; mode = 2'd2; ramp_step = 12'd3;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", dac_valid, 1'b0);
    chk("midrst_i1", dac_data_i1, 12'h000);
    chk("midrst_q2", dac_data_q2, 12'h000);
    chk("midrst_r1", dac_r1_mode, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    expect_strobe("post_rst_s0", 12'h000);

    // Randomised segments.
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(1, 0) == 1) begin
        enable      = 1'b0;
        mode        = 2'($urandom_range(3, 0));
        r1_mode     = 1'($urandom_range(1, 0));
        half_period = 16'($urandom_range(4, 0));
        ramp_step   = 12'($urandom);
        const_i     = 12'($urandom);
        const_q     = 12'($urandom);
        repeat ($urandom_range(3, 1)) @(negedge clk);
      end
      enable = 1'b1;
      len = int'($urandom_range(40, 5));
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        if ($urandom_range(9, 0) == 0) r1_mode = ~r1_mode;
        if ($urandom_range(19, 0) == 0) begin
          const_i = 12'($urandom);
          const_q = 12'($urandom);
        end
        if ($urandom_range(19, 0) == 0) begin
          mode        = 2'(mode + 2'd1 + 2'($urandom_range(2, 0)));
          half_period = 16'($urandom_range(4, 0));
          ramp_step   = 12'($urandom);
        end
      end
    end

    enable = 1'b0;
    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
